gamma_wta_ctrl: RTL and testbench
=================================

# gamma_wta_ctrl

- Clocked sequencer for the asynchronous winner-take-all array.
- Frames each gamma cycle:
  - pulses the WTA reset to clear its latches;
  - opens a fixed-length sampling window;
  - synchronises the WTA one-hot output spikes into the clock domain;
  - captures the first winner and its arrival time;
  - hands the result to the downstream column/readout logic over a valid/ready handshake.
- Sits between the WTA and the synchronous control/readout fabric.

## Interface
Parameters:
- NUM_INPUTS, 16, width of the WTA spike vector.
- GAMMA_CYCLE_WIDTH, 16, width of the window counter, the period input and the reported spike time.
- PULSE_WIDTH, 8, number of cycles wta_rst is held high at the start of each gamma cycle.

Ports. Clock `clk`; reset `rst`, asynchronous, active-high.
- clk  in  1  clock
- rst  in  1  async active-high reset
- enable  in  1  run gamma cycles continuously while high
- gamma_period  in  GAMMA_CYCLE_WIDTH  window length in cycles, latched at CLEAR entry; 0 treated as 1
- wta_spikes  in  NUM_INPUTS  raw, asynchronous WTA output_spikes
- wta_rst  out  1  reset to the WTA
- gamma_start  out  1  one-cycle pulse on the first CLEAR cycle
- result_valid  out  1  result available
- result_ready  in  1  consumer accepts result
- winner_hit  out  1  a spike was seen in the window
- winner_idx  out  $clog2(NUM_INPUTS)  lowest set index of first nonzero sample
- winner_time  out  GAMMA_CYCLE_WIDTH  window count at capture; all-ones if no hit
- onehot_err  out  1  sticky multi-winner flag (see Configuration)

## Operation
FSM states and transitions:
- IDLE
  - wta_rst=1.
  - enable=1 → CLEAR.
- CLEAR
  - wta_rst=1 for exactly PULSE_WIDTH cycles.
  - Latches gamma_period.
  - Clears the synchroniser, capture registers and onehot_err.
  - Then → WINDOW.
- WINDOW
  - wta_rst=0.
  - Counter runs 0..max(period,1)-1, then → REPORT.
  - The counter cannot wrap, because period ≤ 2^W−1.
- REPORT
  - wta_rst=0, so the WTA holds its state.
  - result_valid=1.
  - On valid&ready → CLEAR if enable, else IDLE.

Spike synchronisation:
- 2-flop synchroniser, so captured time = raw arrival + 2 cycles.
- Spikes arriving in the last 2 window cycles are lost.

Capture:
- Occurs on the first WINDOW cycle with a nonzero synced vector.
- winner_idx is the lowest set bit; winner_time is the counter value in that cycle.
- Later samples are ignored for capture.

No hit:
- winner_hit=0, winner_idx=0, winner_time all-ones.

Boundary conditions:
- enable dropping mid-gamma:
  - the current cycle completes through REPORT, then → IDLE;
  - enable is not re-sampled until REPORT exit.
- rst at any time: all state and outputs are forced to reset values immediately (async).

Reset values:
- state IDLE, wta_rst=1.
- gamma_start=0, result_valid=0, winner_hit=0, winner_idx=0, winner_time=0, onehot_err=0.

## Timing
- IDLE with enable=1 → CLEAR at the next edge; gamma_start is high for that first CLEAR cycle only.
- wta_rst falls on the edge entering WINDOW, after exactly PULSE_WIDTH high cycles.
- result_valid rises on the first REPORT cycle, exactly max(period,1) cycles after WINDOW entry.
- Result outputs are registered and stable while result_valid=1.
- With result_ready held high, REPORT lasts 1 cycle; wta_rst rises the cycle after the handshake.
- Back-to-back gamma period = PULSE_WIDTH + max(period,1) + 1 cycles.
- Consumer backpressure: the FSM stalls in REPORT; it never drops or overwrites a result.

## Configuration
Macro `WTA_ONEHOT_CHECK_EN`:
- Defined:
  - onehot_err is set when any WINDOW-cycle synced sample has more than one bit set;
  - it is sticky until the next CLEAR or rst;
  - it is valid alongside result_valid.
- Undefined: onehot_err is tied to 0 and no checker logic is built.
- Capture behaviour is identical in both builds.

## Structure
- Package gamma_wta_ctrl_pkg:
  - state enum (IDLE, CLEAR, WINDOW, REPORT);
  - NO_HIT_TIME constant as all-ones of GAMMA_CYCLE_WIDTH, parameterised via function.
- Sub-module wta_prio_enc: combinational lowest-set-bit encoder producing index plus any-bit-set.
- The synchroniser and FSM stay in the top module.

## Test plan
1. rst asserted mid-WINDOW → same cycle: wta_rst=1, result_valid=0, onehot_err=0; after release, state IDLE.
2. enable=1, period=20, raw spike bit 5 held from window cycle 3 → winner_hit=1, idx=5, time=5; result_valid on window-entry+20.
3. period=20, no spikes → hit=0, idx=0, time=16'hFFFF; wta_rst high exactly 8 cycles in the next CLEAR.
4. Bits 3 and 9 rise together at cycle 4 → idx=3, time=6; onehot_err=1 with the macro, 0 without.
5. result_ready low for 10 REPORT cycles → outputs stable, no CLEAR; ready=1 → gamma_start pulses on the next cycle.
6. period=0, enable dropped during WINDOW → WINDOW lasts 1 cycle, REPORT completes, then IDLE with wta_rst=1.

Source files
------------

// File: rtl/gamma_wta_ctrl_pkg.sv
// rtl/gamma_wta_ctrl_pkg.sv - shared types and constants for the gamma-cycle WTA sequencer
package gamma_wta_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        WINDOW,
        REPORT
    } state_t;

    localparam int MAX_TIME_W = 32;

    // All-ones of the requested width, used as the "no winner" arrival time.
    function automatic logic [MAX_TIME_W-1:0] no_hit_time(input int width);
        logic [MAX_TIME_W-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_TIME_W; i++) begin
            if (i < width) r[i] = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/gamma_wta_ctrl_if.sv
// rtl/gamma_wta_ctrl_if.sv - winner result handshake from the sequencer to readout
interface gamma_wta_ctrl_if #(
    parameter int NUM_INPUTS        = 16,
    parameter int GAMMA_CYCLE_WIDTH = 16
);
    localparam int IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

    logic                         result_valid;
    logic                         result_ready;
    logic                         winner_hit;
    logic [IDX_W-1:0]             winner_idx;
    logic [GAMMA_CYCLE_WIDTH-1:0] winner_time;
    logic                         onehot_err;

    modport master (
        output result_valid, winner_hit, winner_idx, winner_time, onehot_err,
        input  result_ready
    );

    modport slave (
        input  result_valid, winner_hit, winner_idx, winner_time, onehot_err,
        output result_ready
    );

endinterface

// File: rtl/wta_prio_enc.sv
// rtl/wta_prio_enc.sv - combinational lowest-set-bit encoder with any-bit-set flag
module wta_prio_enc #(
    parameter int N     = 16,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     vec,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Scan from the top down so the lowest set bit is the last assignment.
    always_comb begin
        idx = '0;
        any = |vec;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) idx = IDX_W'(i);
        end
    end

endmodule

// File: rtl/gamma_wta_ctrl.sv
// rtl/gamma_wta_ctrl.sv - gamma-cycle sequencer for the async WTA array; WTA_ONEHOT_CHECK_EN adds the multi-winner checker
module gamma_wta_ctrl
    import gamma_wta_ctrl_pkg::*;
#(
    parameter int NUM_INPUTS        = 16,
    parameter int GAMMA_CYCLE_WIDTH = 16,
    parameter int PULSE_WIDTH       = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic [GAMMA_CYCLE_WIDTH-1:0] gamma_period,
    input  logic [NUM_INPUTS-1:0]        wta_spikes,
    output logic                         wta_rst,
    output logic                         gamma_start,
    gamma_wta_ctrl_if.master             result
);

    localparam int GCW   = GAMMA_CYCLE_WIDTH;
    localparam int IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam int PCW   = $clog2(PULSE_WIDTH + 1);
    localparam logic [PCW-1:0] PULSE_LAST  = PCW'(PULSE_WIDTH - 1);
    localparam logic [GCW-1:0] NO_HIT_TIME = GCW'(no_hit_time(GCW));

    state_t                  state, state_nxt;
    logic [PCW-1:0]          pulse_cnt;
    logic [GCW-1:0]          win_cnt;
    logic [GCW-1:0]          win_last;
    logic [NUM_INPUTS-1:0]   sync_q1, sync_q2;
    logic [IDX_W-1:0]        enc_idx;
    logic                    enc_any;

    wta_prio_enc #(.N(NUM_INPUTS), .IDX_W(IDX_W)) u_prio_enc (
        .vec (sync_q2),
        .idx (enc_idx),
        .any (enc_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt           = state;
        wta_rst             = 1'b1;
        gamma_start         = 1'b0;
        result.result_valid = 1'b0;
        case (state)
            IDLE: begin
                if (enable) state_nxt = CLEAR;
            end
            CLEAR: begin
                gamma_start = (pulse_cnt == '0);
                if (pulse_cnt == PULSE_LAST) state_nxt = WINDOW;
            end
            WINDOW: begin
                wta_rst = 1'b0;
                if (win_cnt == win_last) state_nxt = REPORT;
            end
            REPORT: begin
                wta_rst             = 1'b0;
                result.result_valid = 1'b1;
                // enable is only consulted here, so a drop mid-cycle still reports.
                if (result.result_ready) state_nxt = enable ? CLEAR : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pulse_cnt <= '0;
            win_cnt   <= '0;
            win_last  <= '0;
            sync_q1   <= '0;
            sync_q2   <= '0;
        end else begin
            pulse_cnt <= (state == CLEAR)  ? pulse_cnt + 1'b1 : '0;
            win_cnt   <= (state == WINDOW) ? win_cnt + 1'b1   : '0;
            if (state == CLEAR && pulse_cnt == '0) begin
                win_last <= (gamma_period == '0) ? '0 : gamma_period - 1'b1;
            end
            if (state == CLEAR) begin
                sync_q1 <= '0;
                sync_q2 <= '0;
            end else begin
                sync_q1 <= wta_spikes;
                sync_q2 <= sync_q1;
            end
        end
    end

    // First nonzero synced sample in the window wins; later samples are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result.winner_hit  <= 1'b0;
            result.winner_idx  <= '0;
            result.winner_time <= '0;
        end else if (state == CLEAR) begin
            result.winner_hit  <= 1'b0;
            result.winner_idx  <= '0;
            result.winner_time <= NO_HIT_TIME;
        end else if (state == WINDOW && !result.winner_hit && enc_any) begin
            result.winner_hit  <= 1'b1;
            result.winner_idx  <= enc_idx;
            result.winner_time <= win_cnt;
        end
    end

`ifdef WTA_ONEHOT_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result.onehot_err <= 1'b0;
        end else if (state == CLEAR) begin
            result.onehot_err <= 1'b0;
        end else if (state == WINDOW && ((sync_q2 & (sync_q2 - 1'b1)) != '0)) begin
            result.onehot_err <= 1'b1;
        end
    end
`else
    assign result.onehot_err = 1'b0;
`endif

endmodule

// File: tb/tb_gamma_wta_ctrl.sv
// tb/tb_gamma_wta_ctrl.sv - directed self-checking bench for gamma_wta_ctrl
module tb_gamma_wta_ctrl;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [15:0] gamma_period;
    logic [15:0] wta_spikes;
    logic        wta_rst;
    logic        gamma_start;

    int errors = 0;
    int checks = 0;

`ifdef WTA_ONEHOT_CHECK_EN
    localparam logic OH_EXP = 1'b1;
`else
    localparam logic OH_EXP = 1'b0;
`endif

    gamma_wta_ctrl_if #(.NUM_INPUTS(16), .GAMMA_CYCLE_WIDTH(16)) res_if ();

    gamma_wta_ctrl #(
        .NUM_INPUTS        (16),
        .GAMMA_CYCLE_WIDTH (16),
        .PULSE_WIDTH       (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .gamma_period (gamma_period),
        .wta_spikes   (wta_spikes),
        .wta_rst      (wta_rst),
        .gamma_start  (gamma_start),
        .result       (res_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for gamma_start, then counts wta_rst-high cycles; returns at window cycle 0.
    task automatic wait_window(output int pulse);
        int n;
        n = 0;
        pulse = 0;
        while (!gamma_start && n < 100) begin
            tick();
            n++;
        end
        check("gamma_start_seen", 32'(gamma_start), 32'd1);
        n = 0;
        while (wta_rst && n < 100) begin
            pulse++;
            tick();
            n++;
        end
    endtask

    // Applies vec at window cycle 'at' and counts edges until result_valid.
    task automatic run_window(input int at, input logic [15:0] vec, output int k);
        k = 0;
        wta_spikes = '0;
        while (!res_if.result_valid && k < 1000) begin
            if (k == at) wta_spikes = vec;
            tick();
            k++;
        end
        wta_spikes = '0;
    endtask

    int pulse;
    int k;

    initial begin
        rst                 = 1'b1;
        enable              = 1'b0;
        gamma_period        = 16'd20;
        wta_spikes          = '0;
        res_if.result_ready = 1'b0;
        #23;
        check("rst_wta_rst",  32'(wta_rst),             32'd1);
        check("rst_start",    32'(gamma_start),         32'd0);
        check("rst_valid",    32'(res_if.result_valid), 32'd0);
        check("rst_hit",      32'(res_if.winner_hit),   32'd0);
        check("rst_idx",      32'(res_if.winner_idx),   32'd0);
        check("rst_time",     32'(res_if.winner_time),  32'd0);
        check("rst_onehot",   32'(res_if.onehot_err),   32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Single spike on bit 5 from window cycle 3.
        enable = 1'b1;
        wait_window(pulse);
        check("t2_pulse", 32'(pulse), 32'd8);
        run_window(3, 16'h0020, k);
        check("t2_latency", 32'(k), 32'd20);
        check("t2_hit",    32'(res_if.winner_hit),  32'd1);
        check("t2_idx",    32'(res_if.winner_idx),  32'd5);
        check("t2_time",   32'(res_if.winner_time), 32'd5);
        check("t2_onehot", 32'(res_if.onehot_err),  32'd0);

        // No spikes; ready held so wta_rst rises right after the handshake.
        res_if.result_ready = 1'b1;
        tick();
        res_if.result_ready = 1'b0;
        check("t3_start", 32'(gamma_start), 32'd1);
        check("t3_wta_rst", 32'(wta_rst), 32'd1);
        wait_window(pulse);
        check("t3_pulse", 32'(pulse), 32'd8);
        run_window(-1, 16'h0000, k);
        check("t3_latency", 32'(k), 32'd20);
        check("t3_hit",  32'(res_if.winner_hit),  32'd0);
        check("t3_idx",  32'(res_if.winner_idx),  32'd0);
        check("t3_time", 32'(res_if.winner_time), 32'h0000ffff);

        // Bits 3 and 9 together at window cycle 4.
        res_if.result_ready = 1'b1;
        tick();
        res_if.result_ready = 1'b0;
        wait_window(pulse);
        check("t4_pulse", 32'(pulse), 32'd8);
        run_window(4, 16'h0208, k);
        check("t4_latency", 32'(k), 32'd20);
        check("t4_hit",    32'(res_if.winner_hit),  32'd1);
        check("t4_idx",    32'(res_if.winner_idx),  32'd3);
        check("t4_time",   32'(res_if.winner_time), 32'd6);
        check("t4_onehot", 32'(res_if.onehot_err),  32'(OH_EXP));

        // Backpressure: 10 REPORT cycles with ready low.
        for (int i = 0; i < 10; i++) begin
            check("t5_valid", 32'(res_if.result_valid), 32'd1);
            check("t5_time",  32'(res_if.winner_time),  32'd6);
            check("t5_idx",   32'(res_if.winner_idx),   32'd3);
            check("t5_start", 32'(gamma_start),         32'd0);
            tick();
        end
        check("t5_onehot_hold", 32'(res_if.onehot_err), 32'(OH_EXP));
        gamma_period        = 16'd0;
        res_if.result_ready = 1'b1;
        tick();
        res_if.result_ready = 1'b0;
        check("t5_start_after", 32'(gamma_start), 32'd1);

        // period 0, enable dropped in the single window cycle.
        wait_window(pulse);
        check("t6_pulse", 32'(pulse), 32'd8);
        enable = 1'b0;
        run_window(-1, 16'h0000, k);
        check("t6_latency", 32'(k), 32'd1);
        check("t6_time", 32'(res_if.winner_time), 32'h0000ffff);
        res_if.result_ready = 1'b1;
        tick();
        res_if.result_ready = 1'b0;
        check("t6_idle_wta_rst", 32'(wta_rst), 32'd1);
        check("t6_idle_valid",   32'(res_if.result_valid), 32'd0);
        tick();
        tick();
        tick();
        check("t6_idle_start",   32'(gamma_start), 32'd0);
        check("t6_idle_wta_rst2", 32'(wta_rst), 32'd1);

        // Async reset mid-window.
        gamma_period = 16'd20;
        enable       = 1'b1;
        wait_window(pulse);
        wta_spikes = 16'h0208;
        for (int i = 0; i < 5; i++) tick();
        check("t1_pre_wta_rst", 32'(wta_rst), 32'd0);
        check("t1_pre_onehot",  32'(res_if.onehot_err), 32'(OH_EXP));
        #2;
        rst = 1'b1;
        #1;
        check("t1_wta_rst", 32'(wta_rst),             32'd1);
        check("t1_valid",   32'(res_if.result_valid), 32'd0);
        check("t1_onehot",  32'(res_if.onehot_err),   32'd0);
        check("t1_hit",     32'(res_if.winner_hit),   32'd0);
        enable     = 1'b0;
        wta_spikes = '0;
        @(negedge clk);
        rst = 1'b0;
        tick();
        tick();
        check("t1_idle_wta_rst", 32'(wta_rst),     32'd1);
        check("t1_idle_start",   32'(gamma_start), 32'd0);
        check("t1_idle_valid",   32'(res_if.result_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
